bcd_converter: RTL and testbench

Parametrised, handshaked binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one binary bit per clock. It replaces the free-running converter in the display path. Conversion starts only on a valid/ready input transfer, and the result is held until the consumer accepts it. It also reports the number of significant digits for leading-zero blanking and, as a build option, accepts two's-complement input.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adjust.sv | 16 +
 rtl/bcd_converter.sv | 146 ++++++++++++++
 tb/tb_bcd_converter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the handshaked binary-to-BCD converter.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Decimal digits needed for the largest BIN_W-bit value, ceil(binW*log10(2)).
  function automatic int minDigits(input int binW);
    return (binW * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIGIT_W'(5)) begin
      digit_o = digit_i + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_converter.sv
// Handshaked binary-to-BCD converter, one binary bit per clock (shift-and-add-3).
// Build option BCD_SIGNED_EN: in_data_i is two's complement and out_neg_o reports the sign.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W = 32,
  parameter int DIG_N = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [BIN_W-1:0]             in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [DIGIT_W*DIG_N-1:0]     out_bcd_o,
  output logic [$clog2(DIG_N+1)-1:0]   out_ndigits_o,
  output logic                         out_neg_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  localparam int BCD_W  = DIGIT_W * DIG_N;
  localparam int WORK_W = BIN_W + BCD_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int ND_W   = $clog2(DIG_N + 1);

  if (BIN_W < 1) begin : gWidthCheck
    $error("bcd_converter: BIN_W must be at least 1");
  end
  if (DIG_N < minDigits(BIN_W)) begin : gDigitCheck
    $error("bcd_converter: DIG_N too small for BIN_W");
  end

  state_t             state_q, state_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [ND_W-1:0]    ndig_q, ndig_d;

  logic [BIN_W-1:0]   inMag;
  logic               inNeg;
  logic [BCD_W-1:0]   adjDigits;
  logic [WORK_W-1:0]  adjWork;
  logic [WORK_W-1:0]  shiftedWork;
  logic [BCD_W-1:0]   shiftedBcd;
  logic [ND_W-1:0]    ndCalc;

`ifdef BCD_SIGNED_EN
  // Negation in BIN_W bits maps the most negative value onto its own magnitude.
  assign inNeg = in_data_i[BIN_W-1];
  assign inMag = inNeg ? (~in_data_i + BIN_W'(1)) : in_data_i;
`else
  assign inNeg = 1'b0;
  assign inMag = in_data_i;
`endif

  for (genvar g = 0; g < DIG_N; g++) begin : gAdjust
    bcd_digit_adjust uAdjust (
      .digit_i (work_q[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .digit_o (adjDigits[DIGIT_W*g +: DIGIT_W])
    );
  end

  assign adjWork     = {adjDigits, work_q[BIN_W-1:0]};
  assign shiftedWork = {adjWork[WORK_W-2:0], 1'b0};
  assign shiftedBcd  = shiftedWork[WORK_W-1:BIN_W];

  // Highest non-zero digit plus one; a zero result still shows one digit.
  always_comb begin
    ndCalc = ND_W'(1);
    for (int k = 0; k < DIG_N; k++) begin
      if (shiftedBcd[DIGIT_W*k +: DIGIT_W] != '0) begin
        ndCalc = ND_W'(k + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    ndig_d  = ndig_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          work_d  = {{BCD_W{1'b0}}, inMag};
          cnt_d   = '0;
          sign_d  = inNeg;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shiftedWork;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = shiftedBcd;
          ndig_d  = ndCalc;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      ndig_q  <= ND_W'(1);
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      ndig_q  <= ndig_d;
    end
  end

  // A set top bit would be shifted out of the digit field; digits must stay decimal.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == SHIFT) begin
      assert (adjWork[WORK_W-1] == 1'b0);
      for (int k = 0; k < DIG_N; k++) begin
        assert (work_q[BIN_W + DIGIT_W*k +: DIGIT_W] <= DIGIT_W'(9));
      end
    end
  end

  assign in_ready_o    = (state_q == IDLE) && !rst_i;
  assign out_valid_o   = (state_q == DONE);
  assign out_bcd_o     = bcd_q;
  assign out_ndigits_o = ndig_q;
  assign out_neg_o     = sign_q;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter (BIN_W=16, DIG_N=5); expectations come from a divide-by-ten model.
module tb_bcd_converter;

  localparam int BIN_W = 16;
  localparam int DIG_N = 5;
  localparam int ND_W  = $clog2(DIG_N + 1);

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [BIN_W-1:0]  inData   = '0;
  logic              inValid  = 1'b0;
  logic              inReady;
  logic [4*DIG_N-1:0] outBcd;
  logic [ND_W-1:0]   outNd;
  logic              outNeg;
  logic              outValid;
  logic              outReady = 1'b0;

  typedef struct {
    logic [4*DIG_N-1:0] bcd;
    logic [ND_W-1:0]    nd;
    logic               neg;
  } exp_t;

  exp_t expQ[$];
  int   outTimes[$];
  int   cycleCount  = 0;
  int   assertCount = 0;
  int   failCount   = 0;

  bcd_converter #(.BIN_W(BIN_W), .DIG_N(DIG_N)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .in_data_i     (inData),
    .in_valid_i    (inValid),
    .in_ready_o    (inReady),
    .out_bcd_o     (outBcd),
    .out_ndigits_o (outNd),
    .out_neg_o     (outNeg),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady)
  );

  // Free-running clock and a cycle counter used to measure result spacing.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion by repeated division, independent of the shift-and-add-3 datapath.
  function automatic exp_t modelOf(input logic [BIN_W-1:0] v);
    exp_t        m;
    int unsigned mag;
    logic        neg;
`ifdef BCD_SIGNED_EN
    neg = v[BIN_W-1];
    mag = neg ? (32'd65536 - 32'(v)) : 32'(v);
`else
    neg = 1'b0;
    mag = 32'(v);
`endif
    m.bcd = '0;
    m.nd  = ND_W'(1);
    m.neg = neg;
    for (int k = 0; k < DIG_N; k++) begin
      m.bcd[4*k +: 4] = 4'(mag % 10);
      if ((mag % 10) != 0) m.nd = ND_W'(k + 1);
      mag = mag / 10;
    end
    return m;
  endfunction

  // Monitor: push on input transfers, pop and compare on output transfers.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expQ.delete();
    end else begin
      if (inValid && inReady) expQ.push_back(modelOf(inData));
      if (outValid && outReady) begin
        checkOutput("readyExcl", 32'(inReady), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedResult", 32'(outValid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("bcd", 32'(outBcd), 32'(e.bcd));
          checkOutput("ndigits", 32'(outNd), 32'(e.nd));
          checkOutput("neg", 32'(outNeg), 32'(e.neg));
          outTimes.push_back(cycleCount);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [BIN_W-1:0] v);
    bit got = 1'b0;
    @(posedge clk); #1;
    inData  = v;
    inValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inReady) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("inReadyTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !outValid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int base;
    bit seen;
    logic [BIN_W-1:0] b2b [3];
    logic [BIN_W-1:0] edgeVals [6];

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 32'(inReady), 32'd0);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstOutBcd", 32'(outBcd), 32'd0);
    checkOutput("rstNdigits", 32'(outNd), 32'd1);
    checkOutput("rstNeg", 32'(outNeg), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", 32'(inReady), 32'd1);

    $display("[TB] latency with all-ones input");
    outReady = 1'b1;
    applyStimulus(16'hFFFF);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (outValid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("latencySeen", 32'(seen), 32'd1);
    checkOutput("latency", 32'(lat), 32'(BIN_W + 1));
    waitDrain();

    $display("[TB] boundary values");
    edgeVals = '{16'd0, 16'd9, 16'd10, 16'h8000, 16'h7FFF, 16'hFFFF};
    foreach (edgeVals[i]) begin
      applyStimulus(edgeVals[i]);
      waitDrain();
    end

    $display("[TB] back-pressure hold");
    outReady = 1'b0;
    applyStimulus(16'd1234);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (outValid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("holdSeen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      inValid = (i == 3);
      inData  = 16'd999;
      @(negedge clk);
      checkOutput("holdBcd", 32'(outBcd), 32'h01234);
      checkOutput("holdReady", 32'(inReady), 32'd0);
      checkOutput("holdValid", 32'(outValid), 32'd1);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    waitDrain();
    applyStimulus(16'd55);
    waitDrain();

    $display("[TB] reset during conversion");
    applyStimulus(16'd777);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid", 32'(outValid), 32'd0);
    checkOutput("midRstReady", 32'(inReady), 32'd1);
    applyStimulus(16'd42);
    waitDrain();

    $display("[TB] back-to-back transfers");
    b2b  = '{16'd1, 16'(99999 % 65536), 16'd500};
    base = outTimes.size();
    @(posedge clk); #1;
    inValid = 1'b1;
    foreach (b2b[i]) begin
      inData = b2b[i];
      seen   = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (inReady) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) checkOutput("b2bReadyTimeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    waitDrain();
    checkOutput("b2bCount", 32'(outTimes.size() - base), 32'd3);
    if (outTimes.size() - base == 3) begin
      checkOutput("b2bSpacing1", 32'(outTimes[base+1] - outTimes[base]), 32'(BIN_W + 2));
      checkOutput("b2bSpacing2", 32'(outTimes[base+2] - outTimes[base+1]), 32'(BIN_W + 2));
    end

    $display("[TB] random values");
    repeat (6) begin
      applyStimulus(16'($urandom_range(0, 65535)));
      waitDrain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
